// File: rtl/wb_sram_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_sram_if (interface wb_if)
// Description : Wishbone B4 registered-feedback bus bundle.
//               master modport drives the request fields (adr, dat_w, cyc,
//               stb, we, sel, cti, bte) and receives dat_r/ack/err.
//               slave modport is the mirror image.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW-1:0]   dat_r;
    logic            cyc;
    logic            stb;
    logic            we;
    logic [DW/8-1:0] sel;
    logic [2:0]      cti;
    logic [1:0]      bte;
    logic            ack;
    logic            err;

    modport master (
        output adr, dat_w, cyc, stb, we, sel, cti, bte,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, dat_w, cyc, stb, we, sel, cti, bte,
        output dat_r, ack, err
    );
endinterface
`default_nettype wire

// File: rtl/wb_sram.sv
`default_nettype none
// ============================================================================
// Module      : wb_sram
// Description : Single-port Wishbone B4 registered-feedback SRAM slave.
//               Classic single cycles plus incrementing bursts (linear and
//               wrap-4/8/16) at one beat per clock.
// Ports       : clk  - clock, rising edge
//               rstn - asynchronous active-low reset
//               s    - Wishbone slave port (wb_if.slave)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_sram #(
    parameter int    WB_ADDR_WIDTH = 32,
    parameter int    WB_DATA_WIDTH = 32,
    parameter int    MEM_ADDR_BITS = 10,
    parameter string INIT_FILE     = ""
) (
    input  wire logic clk,
    input  wire logic rstn,
    wb_if.slave       s
);
    localparam int SEL_WIDTH = WB_DATA_WIDTH / 8;
    localparam int OFS       = $clog2(SEL_WIDTH);
    localparam int DEPTH     = 1 << MEM_ADDR_BITS;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SINGLE = 2'd1,
        ST_BURST  = 2'd2
    } state_t;

    logic [WB_DATA_WIDTH-1:0] mem [DEPTH];

    state_t                   state_q, state_d;
    logic [MEM_ADDR_BITS-1:0] cur_q, cur_d;
    logic [WB_DATA_WIDTH-1:0] dat_r_q, dat_r_d;

    logic [MEM_ADDR_BITS-1:0] w_widx;
    logic [MEM_ADDR_BITS-1:0] w_wrap_mask;
    logic [MEM_ADDR_BITS-1:0] w_nxt;
    logic                     w_ack;
    logic                     w_wr_en;
    logic                     w_unused;

    // Bits above the window were already decoded by the interconnect and the
    // byte-offset bits are replaced by SEL, so only the word index is used.
    assign w_widx   = s.adr[OFS +: MEM_ADDR_BITS];
    assign w_unused = ^s.adr;

    // Burst wrap: bits inside the mask advance, bits outside it hold.
    always_comb begin
        w_wrap_mask = '1;
        case (s.bte)
            2'b01:   w_wrap_mask = MEM_ADDR_BITS'(3);
            2'b10:   w_wrap_mask = MEM_ADDR_BITS'(7);
            2'b11:   w_wrap_mask = MEM_ADDR_BITS'(15);
            default: w_wrap_mask = '1;
        endcase
    end

    assign w_nxt = (cur_q & ~w_wrap_mask) | ((cur_q + MEM_ADDR_BITS'(1)) & w_wrap_mask);

    // ACK is the only input-to-output combinational path. Since the state
    // register resets asynchronously, ACK also falls as soon as rstn asserts.
    always_comb begin
        w_ack = 1'b0;
        if (state_q == ST_SINGLE || state_q == ST_BURST) begin
            w_ack = s.cyc & s.stb;
        end
    end

    assign w_wr_en = w_ack & s.stb & s.we;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        dat_r_d = dat_r_q;
        case (state_q)
            ST_IDLE: begin
                if (s.cyc && s.stb) begin
                    cur_d   = w_widx;
                    dat_r_d = mem[w_widx];
                    state_d = (s.cti == CTI_INCR) ? ST_BURST : ST_SINGLE;
                end
            end
            ST_SINGLE: begin
                // One-cycle ACK; a held STB is re-decoded from IDLE.
                state_d = ST_IDLE;
            end
            ST_BURST: begin
                if (!s.cyc) begin
                    state_d = ST_IDLE;
                end else if (s.stb) begin
                    // Prefetch the next beat so DAT_R is ready on the next ACK.
                    cur_d   = w_nxt;
                    dat_r_d = mem[w_nxt];
                    if (s.cti == CTI_END || s.cti == CTI_CLASSIC) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            dat_r_q <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            dat_r_q <= dat_r_d;
        end
    end

    // Memory array is never reset; byte lanes gated by SEL.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < SEL_WIDTH; i++) begin
                if (s.sel[i]) begin
                    mem[cur_q][8*i +: 8] <= s.dat_w[8*i +: 8];
                end
            end
        end
    end

    assign s.dat_r = dat_r_q;
    assign s.ack   = w_ack;
    assign s.err   = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_wb_sram.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_sram
// Description : Self-checking bench for wb_sram (32-bit data, 256 words).
//               Classic cycles run from a vector table; bursts, wait states,
//               abort and mid-burst reset are hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_sram;
    logic clk;
    logic rstn;

    wb_if #(.AW(32), .DW(32)) bus ();

    wb_sram #(
        .WB_ADDR_WIDTH (32),
        .WB_DATA_WIDTH (32),
        .MEM_ADDR_BITS (8),
        .INIT_FILE     ("")
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .s    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] wdat;
        logic [31:0] exp;
    } vec_t;

    vec_t        vec [0:15];
    logic [31:0] bw  [0:255];
    logic [31:0] be  [0:7];

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] DA = 32'hA0A0A0A0;
    localparam logic [31:0] DB = 32'hB1B1B1B1;
    localparam logic [31:0] DC = 32'hC2C2C2C2;
    localparam logic [31:0] DD = 32'hD3D3D3D3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic classic(input vec_t v, input int idx);
        int lat;
        @(posedge clk); #1;
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = v.we; bus.adr = v.adr;
        bus.sel = v.sel; bus.dat_w = v.wdat; bus.cti = 3'b000; bus.bte = 2'b00;
        @(negedge clk);
        check($sformatf("vec%0d_pre_ack", idx), 32'(bus.ack), 32'd0);
        lat = 0;
        do begin
            @(posedge clk); @(negedge clk); lat++;
        end while (!bus.ack && lat < 8);
        check($sformatf("vec%0d_latency", idx), 32'(lat), 32'd1);
        if (!v.we) check($sformatf("vec%0d_rdata", idx), bus.dat_r, v.exp);
        @(posedge clk); @(negedge clk);
        check($sformatf("vec%0d_ack_pulse", idx), 32'(bus.ack), 32'd0);
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    endtask

    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) classic(vec[i], i);
    endtask

    // Burst of n beats; bw[] supplies write data, be[] expected read data.
    // Optional STB gap of stall_len cycles after beat stall_after, during
    // which DAT_R must hold stall_hold.
    task automatic burst(input string tag, input logic we, input logic [31:0] adr0,
                         input logic [1:0] bte, input int n, input int stall_after,
                         input int stall_len, input logic [31:0] stall_hold);
        int waited;
        @(posedge clk); #1;
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we; bus.adr = adr0; bus.sel = 4'hF;
        bus.bte = bte; bus.cti = (n == 1) ? 3'b111 : 3'b010; bus.dat_w = bw[0];
        @(posedge clk);
        for (int b = 0; b < n; b++) begin
            waited = 0;
            @(negedge clk);
            while (!bus.ack && waited < 8) begin
                waited++;
                @(negedge clk);
            end
            check($sformatf("%s_beat%0d_wait", tag, b), 32'(waited), 32'd0);
            if (!we) check($sformatf("%s_beat%0d_rdata", tag, b), bus.dat_r, be[b]);
            @(posedge clk); #1;
            if (b == n - 1) begin
                @(negedge clk);
                check($sformatf("%s_end_ack", tag), 32'(bus.ack), 32'd0);
                bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.cti = 3'b000;
            end else begin
                if (b == stall_after) begin
                    bus.stb = 1'b0;
                    for (int g = 0; g < stall_len; g++) begin
                        @(negedge clk);
                        check($sformatf("%s_gap%0d_ack", tag, g), 32'(bus.ack), 32'd0);
                        check($sformatf("%s_gap%0d_hold", tag, g), bus.dat_r, stall_hold);
                        @(posedge clk); #1;
                    end
                    bus.stb = 1'b1;
                end
                bus.adr   = adr0 + 32'((b + 1) * 4);
                bus.dat_w = bw[b + 1];
                bus.cti   = (b + 1 == n - 1) ? 3'b111 : 3'b010;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //              we    adr            sel    wdat           exp
        vec[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'h1122_3344, 32'h0};
        vec[1]  = '{1'b1, 32'h0000_0010, 4'h3, 32'hDEAD_BEEF, 32'h0};
        vec[2]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'h1122_BEEF};
        vec[3]  = '{1'b1, 32'h0000_0024, 4'hC, 32'hCAFE_F00D, 32'h0};
        vec[4]  = '{1'b0, 32'h0000_0024, 4'hF, 32'h0,         32'hCAFE_0009};
        vec[5]  = '{1'b0, 32'h0000_0414, 4'hF, 32'h0,         32'h0000_0005};
        vec[6]  = '{1'b1, 32'h0000_03FF, 4'h8, 32'hAB00_0000, 32'h0};
        vec[7]  = '{1'b0, 32'h0000_03FC, 4'hF, 32'h0,         32'hAB00_00FF};
        vec[8]  = '{1'b0, 32'h0000_0008, 4'hF, 32'h0,         32'h0000_0002};
        vec[9]  = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,         DC};
        vec[10] = '{1'b0, 32'h0000_0004, 4'hF, 32'h0,         DD};
        vec[11] = '{1'b0, 32'h0000_0008, 4'hF, 32'h0,         DA};
        vec[12] = '{1'b0, 32'h0000_000C, 4'hF, 32'h0,         DB};
        vec[13] = '{1'b0, 32'h0000_0084, 4'hF, 32'h0,         32'h0000_0021};
        vec[14] = '{1'b0, 32'h0000_0080, 4'hF, 32'h0,         32'h5555_0000};
        vec[15] = '{1'b0, 32'h0000_0100, 4'hF, 32'h0,         32'h0000_0040};

        // Reset held with a request pending
        rstn = 1'b0;
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = '0;
        bus.dat_w = '0; bus.sel = 4'hF; bus.cti = 3'b000; bus.bte = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst%0d_ack", i), 32'(bus.ack), 32'd0);
            check($sformatf("rst%0d_dat_r", i), bus.dat_r, 32'd0);
        end
        check("rst_err", 32'(bus.err), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("rst_release_pre_ack", 32'(bus.ack), 32'd0);
        @(posedge clk); @(negedge clk);
        check("rst_first_ack", 32'(bus.ack), 32'd1);
        bus.cyc = 1'b0; bus.stb = 1'b0;

        // Fill mem[i] = i with one 256-beat linear burst
        for (int i = 0; i < 256; i++) bw[i] = 32'(i);
        burst("fill", 1'b1, 32'h0, 2'b00, 256, -1, 0, 32'h0);

        // Linear burst read across the top of memory
        be[0] = 32'hFE; be[1] = 32'hFF; be[2] = 32'h00; be[3] = 32'h01;
        burst("lin", 1'b0, 32'h3F8, 2'b00, 4, -1, 0, 32'h0);

        // Classic writes/reads
        run_vectors(0, 8);

        // Wrap-4 write starting at word 2 -> words 2,3,0,1
        bw[0] = DA; bw[1] = DB; bw[2] = DC; bw[3] = DD;
        burst("wrap4", 1'b1, 32'h08, 2'b01, 4, -1, 0, 32'h0);
        run_vectors(9, 12);

        // Wrap-8 read from word 5 with a 2-cycle STB gap after the third beat
        be[0] = 32'h5; be[1] = 32'h6; be[2] = 32'h7; be[3] = DC;
        be[4] = DD;    be[5] = DA;    be[6] = DB;    be[7] = 32'h1122_BEEF;
        burst("wrap8", 1'b0, 32'h14, 2'b10, 8, 2, 2, DC);

        // Abort: CYC dropped after beat 0 of a write burst
        @(posedge clk); #1;
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 32'h80; bus.sel = 4'hF;
        bus.bte = 2'b00; bus.cti = 3'b010; bus.dat_w = 32'h5555_0000;
        @(posedge clk); @(negedge clk);
        check("abort_beat0_ack", 32'(bus.ack), 32'd1);
        @(posedge clk); #1;
        bus.cyc = 1'b0; bus.adr = 32'h84; bus.dat_w = 32'h5555_0001;
        @(negedge clk);
        check("abort_ack_drop", 32'(bus.ack), 32'd0);
        bus.stb = 1'b0; bus.we = 1'b0; bus.cti = 3'b000;
        run_vectors(13, 14);

        // Reset asserted before the first write edge of a burst
        @(posedge clk); #1;
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 32'h100; bus.sel = 4'hF;
        bus.bte = 2'b00; bus.cti = 3'b010; bus.dat_w = 32'h7777_0000;
        @(posedge clk); @(negedge clk);
        check("midrst_beat0_ack", 32'(bus.ack), 32'd1);
        rstn = 1'b0;
        #1;
        check("midrst_async_ack", 32'(bus.ack), 32'd0);
        check("midrst_dat_r", bus.dat_r, 32'd0);
        @(posedge clk); #1;
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.cti = 3'b000;
        @(posedge clk); #1;
        rstn = 1'b1;
        run_vectors(15, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
